// File: rtl/sig_rom_lut.sv
// Sigmoid lookup ROM with one registered read per clock.
// Table is built from the parameters at elaboration time.
module sig_rom_lut #(
   parameter int INWIDTH   = 6,
   parameter int DATAWIDTH = 16,
   parameter int INFRAC    = 2,
   parameter int OUTFRAC   = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [INWIDTH-1:0]   x,
   output logic [DATAWIDTH-1:0] out
);

   localparam int DEPTH = 2 ** INWIDTH;
   localparam int HALF  = 2 ** (INWIDTH - 1);

   logic [DATAWIDTH-1:0] rom [DEPTH];

   // Raw code k is treated as two's complement before scaling.
   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam int SK =
         (k >= HALF) ? k - DEPTH : k;
      localparam real V =
         real'(SK) / (2.0 ** INFRAC);
      localparam real S =
         (2.0 ** OUTFRAC) / (1.0 + $exp(-V));
      localparam int E = $rtoi(S + 0.5);
      assign rom[k] = E[DATAWIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= rom[x];
      end
   end

endmodule

// File: tb/tb_sig_rom_lut.sv
// Self-checking bench for sig_rom_lut.
// Vector table plus scoreboard queue, one-cycle read latency.
module tb_sig_rom_lut;

   logic        clk;
   logic        rst_n;
   logic [5:0]  x;
   logic [15:0] out;

   int total;
   int bad;
   int sb[$];
   int obs[64];

   typedef struct {
      int code;
      int exp_val;
   } vec_t;

   vec_t vecs[15];

   sig_rom_lut dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x     (x),
      .out   (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model(int s);
      real r;
      r = 16384.0 / (1.0 + $exp(-real'(s) / 4.0));
      return $rtoi(r + 0.5);
   endfunction

   task automatic chk(string name, int got, int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d",
                  name, got, want);
      end
   endtask

   // Drive a code, push its expectation, compare after the edge.
   task automatic step(input int code, input int want,
                       input string name, output int got);
      int e;
      @(negedge clk);
      x = code[5:0];
      sb.push_back(want);
      @(posedge clk);
      #1;
      got = int'(out);
      if (sb.size() == 0) begin
         chk({name, "_sb_empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         chk(name, got, e);
      end
   endtask

   initial begin
      int got;
      int prev;
      int sum;
      int s;

      vecs[0]  = '{0, 8192};
      vecs[1]  = '{1, 9211};
      vecs[2]  = '{2, 10198};
      vecs[3]  = '{3, model(3)};
      vecs[4]  = '{4, 11978};
      vecs[5]  = '{5, model(5)};
      vecs[6]  = '{6, model(6)};
      vecs[7]  = '{7, model(7)};
      vecs[8]  = '{8, model(8)};
      vecs[9]  = '{9, model(9)};
      vecs[10] = '{10, 15141};
      vecs[11] = '{-1, 7173};
      vecs[12] = '{-4, 4406};
      vecs[13] = '{-32, 5};
      vecs[14] = '{31, 16377};

      total = 0;
      bad   = 0;
      x     = '0;
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_out", int'(out), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold", int'(out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_out", int'(out), 0);

      // Sweep 0..10 then negative and extreme codes.
      prev = 0;
      for (int i = 0; i < 15; i++) begin
         step(vecs[i].code, vecs[i].exp_val, "vec", got);
         if (i <= 10) begin
            if (i > 0) chk("sweep_mono", int'(got >= prev), 1);
            prev = got;
         end
      end

      // Exhaustive signed-order sweep.
      prev = -1;
      for (int c = -32; c < 32; c++) begin
         step(c, model(c), "exh", got);
         obs[c + 32] = got;
         chk("exh_mono", int'(got >= prev), 1);
         chk("exh_max", int'(got <= 16384), 1);
         prev = got;
      end
      for (int i = 1; i < 32; i++) begin
         sum = obs[32 + i] + obs[32 - i];
         chk("sym", int'(sum >= 16383 && sum <= 16385), 1);
      end

      // Back-to-back extremes.
      for (int i = 0; i < 8; i++) begin
         s = (i % 2 == 0) ? -32 : 31;
         step(s, (i % 2 == 0) ? 5 : 16377, "alt", got);
      end

      // Reset mid-run with x held at 4.
      step(4, 11978, "pre_rst", got);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_async", int'(out), 0);
      @(posedge clk);
      #1;
      chk("mid_rst_hold", int'(out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_zero", int'(out), 0);
      @(posedge clk);
      #1;
      chk("mid_rel_first", int'(out), 11978);

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
